// File: rtl/accum_olane.sv
// accum_olane: per-row accumulator of delayed partial sums into a FWFT result FIFO; ACCUM_OLANE_SAT_EN selects saturating add (wraps otherwise).
// Latency: result visible one cycle after its last beat's data cycle; backpressure: oready gates pops, a push into a full FIFO is dropped and sets overflow.
module accum_olane #(
    parameter int IWIDTH     = 16,
    parameter int OWIDTH     = 32,
    parameter int DELAY      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ctrl_valid,
    input  logic                          accum_first,
    input  logic                          accum_last,
    input  logic signed [IWIDTH-1:0]      idata,
    output logic [OWIDTH-1:0]             odata,
    output logic                          ovalid,
    input  logic                          oready,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [DELAY-1:0] vld_sr, first_sr, last_sr;
    logic             d_valid, d_first, d_last;
    logic             row_open;

    logic signed [OWIDTH-1:0] ext_i;
    logic [OWIDTH-1:0]        acc, acc_sum, post_sum;

    logic [OWIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic              push_req, push, pop, full;

    // first/last are qualified by ctrl_valid before entering the pipe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_sr   <= '0;
            first_sr <= '0;
            last_sr  <= '0;
        end else begin
            vld_sr[0]   <= ctrl_valid;
            first_sr[0] <= ctrl_valid & accum_first;
            last_sr[0]  <= ctrl_valid & accum_last;
            for (int i = 1; i < DELAY; i++) begin
                vld_sr[i]   <= vld_sr[i-1];
                first_sr[i] <= first_sr[i-1];
                last_sr[i]  <= last_sr[i-1];
            end
        end
    end

    assign d_valid = vld_sr[DELAY-1];
    assign d_first = first_sr[DELAY-1];
    assign d_last  = last_sr[DELAY-1];
    assign ext_i   = OWIDTH'(idata);

`ifdef ACCUM_OLANE_SAT_EN
    logic [OWIDTH:0] wide_sum;
    assign wide_sum = {acc[OWIDTH-1], acc} + {ext_i[OWIDTH-1], ext_i};

    // disagreeing top two bits mean the signed add left the OWIDTH range
    always_comb begin
        acc_sum = wide_sum[OWIDTH-1:0];
        if (wide_sum[OWIDTH] != wide_sum[OWIDTH-1])
            acc_sum = wide_sum[OWIDTH] ? {1'b1, {(OWIDTH-1){1'b0}}}
                                       : {1'b0, {(OWIDTH-1){1'b1}}};
    end
`else
    assign acc_sum = acc + ext_i;
`endif

    assign post_sum = d_first ? ext_i : acc_sum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            row_open <= 1'b0;
        end else if (d_valid) begin
            acc <= post_sum;
            if (d_last)
                row_open <= 1'b0;
            else if (d_first)
                row_open <= 1'b1;
        end
    end

    assign ovalid   = (count != '0);
    assign odata    = mem[rd_ptr];
    assign full     = (count == CW'(FIFO_DEPTH));
    assign pop      = ovalid & oready;
    assign push_req = d_valid & d_last;
    // a same-cycle pop frees the slot, so a full FIFO still accepts
    assign push     = push_req & (~full | pop);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= post_sum;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req & full & ~pop)
                overflow <= 1'b1;
        end
    end

    assign busy = (|vld_sr) | row_open | ovalid;

endmodule

// File: tb/tb_accum_olane.sv
// Randomized and directed bench for accum_olane against a queue-based row/FIFO model.
module tb_accum_olane;
    localparam int IW = 16;
    localparam int OW = 32;
    localparam int DL = 2;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ctrl_valid = 1'b0, accum_first = 1'b0, accum_last = 1'b0, oready = 1'b0;
    logic signed [IW-1:0] idata = '0;
    logic [OW-1:0] odata;
    logic ovalid, overflow, busy;
    logic [$clog2(FD):0] count;

    logic c16_valid = 1'b0, c16_first = 1'b0, c16_last = 1'b0, oready16 = 1'b0;
    logic signed [15:0] idata16 = '0;
    logic [15:0] odata16;
    logic ovalid16, overflow16, busy16;
    logic [$clog2(FD):0] count16;

    always #5 clk = ~clk;

    accum_olane #(.IWIDTH(IW), .OWIDTH(OW), .DELAY(DL), .FIFO_DEPTH(FD)) u_dut (
        .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .accum_first(accum_first),
        .accum_last(accum_last), .idata(idata), .odata(odata), .ovalid(ovalid),
        .oready(oready), .count(count), .overflow(overflow), .busy(busy)
    );

    accum_olane #(.IWIDTH(16), .OWIDTH(16), .DELAY(DL), .FIFO_DEPTH(FD)) u_dut16 (
        .clk(clk), .rst(rst), .ctrl_valid(c16_valid), .accum_first(c16_first),
        .accum_last(c16_last), .idata(idata16), .odata(odata16), .ovalid(ovalid16),
        .oready(oready16), .count(count16), .overflow(overflow16), .busy(busy16)
    );

    typedef struct {
        bit v;
        bit f;
        bit l;
        logic signed [IW-1:0] d;
    } beat_t;

    beat_t             pend[$];   // ctrl beats waiting for their data cycle
    logic [OW-1:0]     q[$];      // expected FIFO contents, head first
    logic signed [OW-1:0] acc_m;
    bit                open_m;
    bit                ovf_m;
    int                n_cmp = 0;
    int                n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [OW-1:0] acc_add(input logic signed [OW-1:0] a,
                                              input logic signed [IW-1:0] d);
        longint s;
        s = longint'(a) + longint'(d);
`ifdef ACCUM_OLANE_SAT_EN
        if (s > 64'sh7FFFFFFF)  s = 64'sh7FFFFFFF;
        if (s < -64'sh80000000) s = -64'sh80000000;
`endif
        return s[OW-1:0];
    endfunction

    task automatic model_reset();
        beat_t e;
        e.v = 0; e.f = 0; e.l = 0; e.d = '0;
        pend.delete();
        for (int i = 0; i < DL; i++) pend.push_back(e);
        q.delete();
        acc_m  = '0;
        open_m = 0;
        ovf_m  = 0;
    endtask

    task automatic check_outputs();
        bit bexp;
        bexp = open_m || (q.size() != 0);
        foreach (pend[i]) if (pend[i].v) bexp = 1;
        check("ovalid", 64'(ovalid), 64'(q.size() != 0));
        if (q.size() != 0) check("odata", 64'(odata), 64'(q[0]));
        check("count", 64'(count), 64'(q.size()));
        check("overflow", 64'(overflow), 64'(ovf_m));
        check("busy", 64'(busy), 64'(bexp));
    endtask

    // Drive one cycle at a negedge, check the current outputs, then advance the model across the edge.
    task automatic step(input bit cv, input bit f, input bit l,
                        input logic signed [IW-1:0] d, input bit ordy);
        beat_t b, fr;
        ctrl_valid  = cv;
        accum_first = f;
        accum_last  = l;
        oready      = ordy;
        fr          = pend[0];
        idata       = fr.v ? fr.d : IW'($urandom);
        check_outputs();
        fr = pend.pop_front();
        if (q.size() != 0 && ordy) void'(q.pop_front());
        if (fr.v) begin
            acc_m = acc_add(fr.f ? '0 : acc_m, fr.d);
            if (fr.l) begin
                if (q.size() < FD) q.push_back(acc_m);
                else ovf_m = 1;
                open_m = 0;
            end else if (fr.f) begin
                open_m = 1;
            end
        end
        b.v = cv; b.f = cv & f; b.l = cv & l; b.d = d;
        pend.push_back(b);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, IW'($urandom), 1);
    endtask

    task automatic do_reset();
        ctrl_valid = 0; accum_first = 0; accum_last = 0;
        rst = 1'b0;
        #1;
        check("rst_ovalid", 64'(ovalid), 64'(0));
        check("rst_count", 64'(count), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // 1,2,3,4 row: result DL+1 cycles after the last ctrl beat
        step(1, 1, 0, 1, 1);
        step(1, 0, 0, 2, 1);
        step(1, 0, 0, 3, 1);
        step(1, 0, 1, 4, 1);
        idle(DL);
        check("r026_vld", 64'(ovalid), 64'(1));
        check("r026_odata", 64'(odata), 64'(10));
        idle(4);

        // single-beat -5, then back-to-back 7,8
        step(1, 1, 1, -16'sd5, 1);
        step(1, 1, 0, 7, 1);
        step(1, 0, 1, 8, 1);
        check("r027_neg", 64'(odata), 64'(32'hFFFFFFFB));
        idle(2);
        check("r027_sum", 64'(odata), 64'(15));
        idle(4);

        // fill with oready low, fifth result dropped
        for (int k = 1; k <= 5; k++) step(1, 1, 1, IW'(k), 0);
        for (int k = 0; k < 4; k++) step(0, 0, 0, IW'($urandom), 0);
        check("r028_count", 64'(count), 64'(FD));
        check("r028_ovf", 64'(overflow), 64'(1));
        for (int k = 1; k <= 4; k++) begin
            check("r028_drain", 64'(odata), 64'(k));
            step(0, 0, 0, IW'($urandom), 1);
        end
        idle(3);

        // reset mid-row discards the partial sum
        step(1, 1, 0, 1, 1);
        step(1, 0, 0, 2, 1);
        idle(2);
        do_reset();
        step(1, 1, 0, 3, 1);
        step(1, 0, 1, 4, 1);
        idle(DL);
        check("r030_odata", 64'(odata), 64'(7));
        idle(4);

        // 16-bit accumulator: 0x7FFF + 0x7FFF
        for (int i = 0; i < 6; i++) begin
            c16_valid = (i < 2);
            c16_first = (i == 0);
            c16_last  = (i == 1);
            idata16   = (i == 2 || i == 3) ? 16'sh7FFF : 16'sh0000;
            @(negedge clk);
        end
        c16_valid = 0; c16_first = 0; c16_last = 0;
        check("r029_vld", 64'(ovalid16), 64'(1));
`ifdef ACCUM_OLANE_SAT_EN
        check("r029_sat", 64'(odata16), 64'(16'h7FFF));
`else
        check("r029_wrap", 64'(odata16), 64'(16'hFFFE));
`endif

        // randomized traffic, heavier backpressure in the second half
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 9) < 6, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0, IW'($urandom),
                 (i < 700) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1));
        end
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/accum_olane.md
ACCUM_OLANE -- requirements
Module: accum_olane

Interface
REQ-001 The block SHALL have parameter IWIDTH, default 16, signed width of each incoming dot-product partial sum.
REQ-002 The block SHALL have parameter OWIDTH, default 32, signed accumulator and output width; OWIDTH >= IWIDTH.
REQ-003 The block SHALL have parameter DELAY, default 2, cycles from ctrl control outputs to matching idata; DELAY >= 1.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4, result FIFO entries; power of two, >= 2.
REQ-005 The block SHALL have one clock and reset that is asynchronous and active-low.
REQ-006 Ports SHALL be:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-low reset.
- ctrl_valid  in  1  ctrl ovalid: a beat was issued this cycle.
- accum_first  in  1  ctrl beat opens a new row.
- accum_last  in  1  ctrl beat closes the row.
- idata  in  IWIDTH  signed partial sum, valid DELAY cycles after its ctrl beat.
- odata  out  OWIDTH  FIFO head result.
- ovalid  out  1  FIFO non-empty.
- oready  in  1  consumer accepts odata.
- count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky: a result was dropped.
- busy  out  1  work in flight.

Function
REQ-007 ctrl_valid, accum_first and accum_last SHALL each pass through a DELAY-stage shift register; stage outputs are d_valid, d_first, d_last.
REQ-008 accum_first/accum_last SHALL be ignored when ctrl_valid is 0.
REQ-009 When d_valid and d_first: acc <= sign-extended idata.
REQ-010 When d_valid and not d_first: acc <= acc + sign-extended idata.
REQ-011 A beat with no preceding first (e.g. right after reset) SHALL accumulate onto the current acc value, 0 after reset.
REQ-012 When d_valid and d_last, the post-update sum (acc + idata, or idata if d_first also set) SHALL be pushed into the FIFO in the same cycle.
REQ-013 Single-beat rows (d_first and d_last together) SHALL push sign-extended idata.
REQ-014 Without d_valid, acc SHALL hold.
REQ-015 FIFO SHALL be first-word-fall-through: odata = head whenever ovalid = 1.
REQ-016 Latency: a last beat at data cycle N SHALL appear on ovalid/odata at cycle N+1 if the FIFO was empty.
REQ-017 Pop SHALL occur when ovalid and oready; odata SHALL be don't-care when ovalid = 0.
REQ-018 Push while full without a same-cycle pop SHALL drop the result, leave the FIFO unchanged and set overflow; overflow clears only on reset.
REQ-019 Push and pop in the same cycle while full SHALL both succeed; count stays FIFO_DEPTH.
REQ-020 Push and pop in the same cycle while count = 1 SHALL keep ovalid = 1 and present the new entry next cycle.
REQ-021 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count = pushes - pops, range 0..FIFO_DEPTH.
REQ-022 busy SHALL be 1 while any delay stage holds valid, a row is open (first seen, last not yet), or count > 0.

Reset
REQ-023 Asserting rst = 0 SHALL immediately clear delay stages, acc, FIFO pointers, count, overflow, ovalid and busy to 0, including mid-row; the first post-reset row requires a fresh first.

Configuration
REQ-024 With macro ACCUM_OLANE_SAT_EN defined, accumulation SHALL saturate to [-2^(OWIDTH-1), 2^(OWIDTH-1)-1].
REQ-025 Without ACCUM_OLANE_SAT_EN, accumulation SHALL wrap modulo 2^OWIDTH.

Verification
REQ-026 Row 1,2,3,4 (first on 1, last on 4), oready = 1 -> one ovalid pulse, odata = 10, DELAY+1 cycles after the last ctrl beat.
REQ-027 Single beat idata = -5 with first and last -> odata = 0xFFFFFFFB; back-to-back row 7,8 -> next odata = 15.
REQ-028 oready = 0, five single-beat rows 1..5 with FIFO_DEPTH = 4 -> count = 4, overflow = 1; then oready = 1 drains 1,2,3,4 in order.
REQ-029 Two beats of 0x7FFF with OWIDTH = IWIDTH = 16 -> odata = 0x7FFF with ACCUM_OLANE_SAT_EN, 0xFFFE without.
REQ-030 rst pulsed low mid-row after beats 1,2; then row 3,4 -> odata = 7, and no stale partial sum is ever output.
